// File: rtl/dvp_tx_emitter.sv
// DVP camera-side transmitter: emits pclk/vsync/href/data frames from a raster pixel stream.
// Build macro DVP_TX_TEST_PATTERN_EN adds tpg_en_i and an internal (col ^ row) pattern source.
module dvp_tx_emitter #(
  parameter int GS_PXL_W = 8,
  parameter int COL_NUM  = 640,
  parameter int ROW_NUM  = 480,
  parameter int VS_CYC   = 3,
  parameter int VBP_CYC  = 8,
  parameter int HBL_CYC  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frm_start_i,
  input  logic [GS_PXL_W-1:0] pxl_i,
  input  logic                pxl_vld_i,
  output logic                pxl_rdy_o,
  output logic                dvp_pclk_o,
  output logic                dvp_vsync_o,
  output logic                dvp_href_o,
  output logic [GS_PXL_W-1:0] dvp_d_o,
  output logic                busy_o,
  output logic                frm_done_o,
  output logic                underflow_o
`ifdef DVP_TX_TEST_PATTERN_EN
  ,
  input  logic                tpg_en_i
`endif
);

  localparam int COL_W  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam int ROW_W  = (ROW_NUM > 0) ? $clog2(ROW_NUM + 1) : 1;
  localparam int BL_MAX = (VS_CYC > VBP_CYC) ? ((VS_CYC > HBL_CYC) ? VS_CYC : HBL_CYC)
                                             : ((VBP_CYC > HBL_CYC) ? VBP_CYC : HBL_CYC);
  localparam int BL_W   = (BL_MAX > 1) ? $clog2(BL_MAX) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_NUM - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROW_NUM);
  localparam logic [BL_W-1:0]  VS_LAST  = BL_W'(VS_CYC - 1);
  localparam logic [BL_W-1:0]  VBP_LAST = BL_W'(VBP_CYC - 1);
  localparam logic [BL_W-1:0]  HBL_LAST = BL_W'(HBL_CYC - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBL} state_t;

  function automatic logic [GS_PXL_W-1:0] tpg_pixel(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row);
    return GS_PXL_W'(32'(col) ^ 32'(row));
  endfunction

  state_t              state, state_nxt;
  logic                ph_p1;
  logic [COL_W-1:0]    col_p0, col_p1;
  logic [ROW_W-1:0]    row_p0, row_p1;
  logic [BL_W-1:0]     cnt_p0, cnt_p1;
  logic                vsync_p0, vsync_p1;
  logic                vld_p0, vld_p1;
  logic [GS_PXL_W-1:0] d_p0, d_p1;
  logic                busy_p0, busy_p1;
  logic                done_p0, done_p1;
  logic                unf_p0, unf_p1;
  logic                tpg_p0, tpg_p1;
  logic                tpg_req;
  logic                line_slot;

`ifdef DVP_TX_TEST_PATTERN_EN
  assign tpg_req = tpg_en_i;
`else
  assign tpg_req = 1'b0;
`endif

  // p0: next-state and next-output decode; only acts on tick cycles (ph=1)
  always_comb begin
    state_nxt = state;
    col_p0    = col_p1;
    row_p0    = row_p1;
    cnt_p0    = cnt_p1;
    vsync_p0  = vsync_p1;
    vld_p0    = vld_p1;
    d_p0      = d_p1;
    busy_p0   = busy_p1;
    done_p0   = 1'b0;
    unf_p0    = unf_p1;
    tpg_p0    = tpg_p1;
    line_slot = 1'b0;
    if (ph_p1) begin
      case (state)
        IDLE: begin
          if (frm_start_i) begin
            state_nxt = VSYNC;
            vsync_p0  = 1'b1;
            busy_p0   = 1'b1;
            unf_p0    = 1'b0;
            tpg_p0    = tpg_req;
            cnt_p0    = '0;
          end
        end
        VSYNC: begin
          if (cnt_p1 == VS_LAST) begin
            state_nxt = VBP;
            vsync_p0  = 1'b0;
            cnt_p0    = '0;
          end else begin
            cnt_p0 = cnt_p1 + 1'b1;
          end
        end
        VBP: begin
          if (cnt_p1 == VBP_LAST) begin
            state_nxt = LINE;
            cnt_p0    = '0;
            line_slot = 1'b1;
          end else begin
            cnt_p0 = cnt_p1 + 1'b1;
          end
        end
        LINE: begin
          if (col_p1 == COL_LAST) begin
            state_nxt = HBL;
            col_p0    = '0;
            row_p0    = row_p1 + 1'b1;
          end else begin
            col_p0    = col_p1 + 1'b1;
            line_slot = 1'b1;
          end
        end
        HBL: begin
          if (cnt_p1 == HBL_LAST) begin
            cnt_p0 = '0;
            if (row_p1 == ROW_END) begin
              state_nxt = IDLE;
              row_p0    = '0;
              busy_p0   = 1'b0;
              done_p0   = 1'b1;
            end else begin
              state_nxt = LINE;
              line_slot = 1'b1;
            end
          end else begin
            cnt_p0 = cnt_p1 + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      vld_p0 = line_slot;
      if (!line_slot)
        d_p0 = '0;
      else if (tpg_p1)
        d_p0 = tpg_pixel(col_p0, row_p1);
      else
        d_p0 = pxl_vld_i ? pxl_i : '0;
      // a missed slot is not retried: the column still advances, data goes out as zero
      if (line_slot && !tpg_p1 && !pxl_vld_i)
        unf_p0 = 1'b1;
    end
  end

  assign pxl_rdy_o = line_slot & ~tpg_p1;

  // p1: registered state, counters and DVP outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_p1    <= 1'b0;
      state    <= IDLE;
      col_p1   <= '0;
      row_p1   <= '0;
      cnt_p1   <= '0;
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      d_p1     <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      unf_p1   <= 1'b0;
      tpg_p1   <= 1'b0;
    end else begin
      ph_p1    <= ~ph_p1;
      state    <= state_nxt;
      col_p1   <= col_p0;
      row_p1   <= row_p0;
      cnt_p1   <= cnt_p0;
      vsync_p1 <= vsync_p0;
      vld_p1   <= vld_p0;
      d_p1     <= d_p0;
      busy_p1  <= busy_p0;
      done_p1  <= done_p0;
      unf_p1   <= unf_p0;
      tpg_p1   <= tpg_p0;
    end
  end

  assign dvp_pclk_o  = ph_p1;
  assign dvp_vsync_o = vsync_p1;
  assign dvp_href_o  = vld_p1;
  assign dvp_d_o     = d_p1;
  assign busy_o      = busy_p1;
  assign frm_done_o  = done_p1;
  assign underflow_o = unf_p1;

endmodule

// File: tb/tb_dvp_tx_emitter.sv
// Directed bench for dvp_tx_emitter on a 4x2 frame (VS=2, VBP=1, HBL=2, 16 pclk periods per frame).
module tb_dvp_tx_emitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       frm_start_i;
  logic [7:0] pxl_i;
  logic       pxl_vld_i;
  logic       pxl_rdy_o;
  logic       dvp_pclk_o;
  logic       dvp_vsync_o;
  logic       dvp_href_o;
  logic [7:0] dvp_d_o;
  logic       busy_o;
  logic       frm_done_o;
  logic       underflow_o;
`ifdef DVP_TX_TEST_PATTERN_EN
  logic       tpg_en_i;
`endif

  always #5 clk = ~clk;

  dvp_tx_emitter #(
    .GS_PXL_W(8), .COL_NUM(4), .ROW_NUM(2), .VS_CYC(2), .VBP_CYC(1), .HBL_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .frm_start_i(frm_start_i),
    .pxl_i(pxl_i), .pxl_vld_i(pxl_vld_i), .pxl_rdy_o(pxl_rdy_o),
    .dvp_pclk_o(dvp_pclk_o), .dvp_vsync_o(dvp_vsync_o), .dvp_href_o(dvp_href_o),
    .dvp_d_o(dvp_d_o), .busy_o(busy_o), .frm_done_o(frm_done_o), .underflow_o(underflow_o)
`ifdef DVP_TX_TEST_PATTERN_EN
    , .tpg_en_i(tpg_en_i)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One trace entry {busy, vsync, href, d} per pclk period, taken while pclk is high.
  logic [10:0] tr [1024];
  int trace_n = 0, done_cnt = 0, done_at = -1, slot_cnt = 0, acc_cnt = 0;

  always @(negedge clk) begin
    if (dvp_pclk_o && trace_n < 1024) begin
      tr[trace_n] <= {busy_o, dvp_vsync_o, dvp_href_o, dvp_d_o};
      trace_n     <= trace_n + 1;
    end
    if (frm_done_o) begin
      done_cnt <= done_cnt + 1;
      done_at  <= trace_n;
    end
    if (pxl_rdy_o) slot_cnt <= slot_cnt + 1;
    if (pxl_rdy_o && pxl_vld_i) acc_cnt <= acc_cnt + 1;
  end

  logic [7:0] base;
  int acc_mark, slot_mark, drop_idx;
  logic vld_on;

  task automatic clk1();
    @(posedge clk);
    #1;
    pxl_i     = 8'(int'(base) + acc_cnt - acc_mark);
    pxl_vld_i = vld_on && ((slot_cnt - slot_mark) != drop_idx);
  endtask

  task automatic start_frame(input logic [7:0] b, input int drop, output int mark);
    base      = b;
    drop_idx  = drop;
    acc_mark  = acc_cnt;
    slot_mark = slot_cnt;
    mark      = trace_n;
    frm_start_i = 1'b1;
    for (int i = 0; i < 8 && !busy_o; i++) clk1();
    check_val("start_busy", 32'(busy_o), 1);
    frm_start_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      clk1();
      n++;
    end
    check_val("done_seen", 32'(done_cnt >= target), 1);
    repeat (4) clk1();
  endtask

  function automatic int find_vs(input int from);
    for (int i = from; i < trace_n; i++)
      if (tr[i][9]) return i;
    return from;
  endfunction

  task automatic check_frame(input string tag, input int f0, input logic [7:0] dat [8]);
    logic [10:0] e, o;
    for (int k = 0; k < 16; k++) begin
      e = '0;
      e[10] = (k < 15);
      e[9]  = (k < 2);
      if (k >= 3 && k <= 6)       e[8:0] = {1'b1, dat[k-3]};
      else if (k >= 9 && k <= 12) e[8:0] = {1'b1, dat[k-5]};
      o = (f0 + k < trace_n) ? tr[f0+k] : '1;
      check_val($sformatf("%s_per%0d", tag, k), 32'(o), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mark, f0, f1, dc;
    rst = 1'b1; frm_start_i = 1'b0; pxl_i = '0; pxl_vld_i = 1'b0;
    vld_on = 1'b1; base = '0; drop_idx = -1; acc_mark = 0; slot_mark = 0;
`ifdef DVP_TX_TEST_PATTERN_EN
    tpg_en_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_pclk",  32'(dvp_pclk_o), 0);
    check_val("rst_vsync", 32'(dvp_vsync_o), 0);
    check_val("rst_href",  32'(dvp_href_o), 0);
    check_val("rst_d",     32'(dvp_d_o), 0);
    check_val("rst_busy",  32'(busy_o), 0);
    check_val("rst_done",  32'(frm_done_o), 0);
    check_val("rst_unf",   32'(underflow_o), 0);
    check_val("rst_rdy",   32'(pxl_rdy_o), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("pclk_%0d", i), 32'(dvp_pclk_o), i % 2);
    end
    clk1();

    // Clean frame with continuous valid pixels
    dc = done_cnt;
    start_frame(8'h10, -1, mark);
    wait_done(dc + 1);
    f0 = find_vs(mark);
    check_frame("frmA", f0, '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17});
    check_val("frmA_done_tick", 32'(done_at - f0), 15);
    check_val("frmA_done_cnt", 32'(done_cnt - dc), 1);
    check_val("frmA_accepted", 32'(acc_cnt - acc_mark), 8);
    check_val("frmA_unf", 32'(underflow_o), 0);

    // Valid dropped for the third slot of line 0
    dc = done_cnt;
    start_frame(8'h20, 2, mark);
    wait_done(dc + 1);
    drop_idx = -1;
    f0 = find_vs(mark);
    check_frame("unf", f0, '{8'h20, 8'h21, 8'h00, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26});
    check_val("unf_accepted", 32'(acc_cnt - acc_mark), 7);
    check_val("unf_set", 32'(underflow_o), 1);
    repeat (6) clk1();
    check_val("unf_sticky", 32'(underflow_o), 1);

    // Back-to-back frames with frm_start_i held high
    base = 8'h30; acc_mark = acc_cnt; slot_mark = slot_cnt; mark = trace_n; dc = done_cnt;
    frm_start_i = 1'b1;
    wait_done(dc + 1);
    check_val("b2b_unf_clr", 32'(underflow_o), 0);
    f0 = find_vs(mark);
    check_val("b2b_done1_tick", 32'(done_at - f0), 15);
    for (int i = 0; i < 8 && !busy_o; i++) clk1();
    frm_start_i = 1'b0;
    wait_done(dc + 2);
    f1 = find_vs(f0 + 2);
    check_val("b2b_gap", 32'(f1 - f0), 16);
    check_frame("b2b1", f0, '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37});
    check_frame("b2b2", f1, '{8'h38, 8'h39, 8'h3a, 8'h3b, 8'h3c, 8'h3d, 8'h3e, 8'h3f});
    check_val("b2b_done2_tick", 32'(done_at - f1), 15);

    // Reset during line 1, then a fresh frame
    dc = done_cnt;
    start_frame(8'h40, -1, mark);
    repeat (20) clk1();
    check_val("mrst_in_line", 32'(dvp_href_o), 1);
    rst = 1'b1;
    clk1();
    check_val("mrst_pclk",  32'(dvp_pclk_o), 0);
    check_val("mrst_vsync", 32'(dvp_vsync_o), 0);
    check_val("mrst_href",  32'(dvp_href_o), 0);
    check_val("mrst_d",     32'(dvp_d_o), 0);
    check_val("mrst_busy",  32'(busy_o), 0);
    check_val("mrst_rdy",   32'(pxl_rdy_o), 0);
    rst = 1'b0;
    repeat (40) clk1();
    check_val("mrst_no_done", 32'(done_cnt - dc), 0);
    check_val("mrst_idle", 32'(busy_o), 0);
    start_frame(8'h50, -1, mark);
    wait_done(dc + 1);
    f0 = find_vs(mark);
    check_frame("post", f0, '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57});
    check_val("post_done_tick", 32'(done_at - f0), 15);

`ifdef DVP_TX_TEST_PATTERN_EN
    // Pattern frame with the upstream stream idle
    tpg_en_i = 1'b1;
    vld_on   = 1'b0;
    dc = done_cnt;
    start_frame(8'h00, -1, mark);
    tpg_en_i = 1'b0;
    wait_done(dc + 1);
    vld_on = 1'b1;
    f0 = find_vs(mark);
    check_frame("tpg", f0, '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h00, 8'h03, 8'h02});
    check_val("tpg_no_rdy", 32'(slot_cnt - slot_mark), 0);
    check_val("tpg_unf", 32'(underflow_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
